// File: rtl/sort_pkg.sv
// Shared types for the sorter output-stream checker: error bit positions and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sort_pkg;

  localparam int ERR_W = 4;

  // Bit positions inside pkt_err / err_sticky.
  typedef enum int {
    ERR_ORDER      = 0,
    ERR_SOP_IN_PKT = 1,
    ERR_OVERLEN    = 2,
    ERR_NO_SOP     = 3
  } err_bit_e;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_e;

endpackage

// File: rtl/sort_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear together with inc loads 1.
// Latency: count reflects clr/inc one cycle after they are sampled.
// Backpressure: none; inc is dropped once the count reaches all-ones.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset, count -> 0
//   clr    synchronous clear, count -> 0 (or 1 when inc is also high)
//   inc    increment request
//   count  current value, sticks at all-ones
module sort_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      // Clear-and-count lets a new run start at 1 in a single cycle.
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sort_stream_checker.sv
// Sink-side monitor: frames sorter output packets, checks non-decreasing payload, length and framing.
// Latency: closing beat at cycle N -> pkt_done and counter update at N+1 (a back-to-back one-beat packet at N+2).
// Backpressure: none; every valid beat is accepted.
//
// Ports:
//   snk_clock, snk_reset            clock, synchronous active-high reset
//   snk_valid/sop/eop/data          incoming beat; sop/eop/data ignored while snk_valid=0
//   stat_clear                      zero pkt_count, err_count and err_sticky next cycle
//   pkt_done                        1-cycle pulse, pkt_len/err/min/max valid and held until next close
//   pkt_count, err_count            saturating totals of closed / errored packets
//   err_sticky                      OR of every pkt_err since reset or stat_clear
module sort_stream_checker
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LENGTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          snk_clock,
  input  logic                          snk_reset,
  input  logic                          snk_valid,
  input  logic                          snk_sop,
  input  logic                          snk_eop,
  input  logic [DATA_WIDTH-1:0]         snk_data,
  input  logic                          stat_clear,
  output logic                          pkt_done,
  output logic [$clog2(MAX_LENGTH):0]   pkt_len,
  output logic [ERR_W-1:0]              pkt_err,
  output logic [DATA_WIDTH-1:0]         pkt_min,
  output logic [DATA_WIDTH-1:0]         pkt_max,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [CNT_WIDTH-1:0]          err_count,
  output logic [ERR_W-1:0]              err_sticky
);

  localparam int                LEN_W   = $clog2(MAX_LENGTH) + 1;
  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(MAX_LENGTH);
  localparam logic [LEN_W-1:0]  LEN_SAT = LEN_W'(MAX_LENGTH + 1);

  typedef struct packed {
    logic [LEN_W-1:0]      len;
    logic [ERR_W-1:0]      err;
    logic [DATA_WIDTH-1:0] data_min;
    logic [DATA_WIDTH-1:0] data_max;
  } result_t;

  // Packet-in-progress state.
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] min_q, min_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  nosop_q, nosop_d;
  logic [LEN_W-1:0]      cnt_q;

  // Result bank.
  logic                  done_q;
  result_t               res_q;
  logic                  pend_vld_q, pend_vld_d;
  result_t               pend_q, pend_d;
  logic [ERR_W-1:0]      sticky_q;

  // Per-cycle decode.
  logic                  start;
  logic                  cnt_inc;
  logic                  close_a;
  logic                  close_b;
  result_t               res_a;
  result_t               res_b;
  logic [ERR_W-1:0]      start_err;
  logic [ERR_W-1:0]      beat_err;
  logic [LEN_W-1:0]      len_next;
  logic                  emit;
  result_t               emit_res;

  // close_a is the packet that closes on this beat; close_b is a one-beat packet
  // opened by a sop that also cut the previous packet short, and is emitted a cycle later.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    min_d     = min_q;
    err_d     = err_q;
    nosop_d   = nosop_q;
    start     = 1'b0;
    cnt_inc   = 1'b0;
    close_a   = 1'b0;
    close_b   = 1'b0;
    res_a     = '0;
    res_b     = '0;
    beat_err  = err_q;
    start_err = '0;
    start_err[ERR_NO_SOP] = nosop_q;
    len_next  = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 1'b1;

    if (snk_valid) begin
      case (state_q)
        IDLE: begin
          if (snk_sop) begin
            start = 1'b1;
          end else begin
            // Orphan beat: flagged on whichever packet closes next.
            nosop_d = 1'b1;
          end
        end
        IN_PKT: begin
          if (snk_sop) begin
            close_a = 1'b1;
            res_a.len      = cnt_q;
            res_a.err      = err_q;
            res_a.err[ERR_SOP_IN_PKT] = 1'b1;
            res_a.data_min = min_q;
            res_a.data_max = prev_q;
            start   = 1'b1;
          end else begin
            if (snk_data < prev_q) begin
              beat_err[ERR_ORDER] = 1'b1;
            end
            if (cnt_q >= LEN_MAX) begin
              beat_err[ERR_OVERLEN] = 1'b1;
            end
            err_d   = beat_err;
            prev_d  = snk_data;
            cnt_inc = 1'b1;
            if (snk_eop) begin
              close_a = 1'b1;
              res_a.len      = len_next;
              res_a.err      = beat_err;
              res_a.data_min = min_q;
              res_a.data_max = snk_data;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (start) begin
        prev_d  = snk_data;
        min_d   = snk_data;
        err_d   = start_err;
        nosop_d = 1'b0;
        cnt_inc = 1'b1;
        state_d = IN_PKT;
        if (snk_eop) begin
          state_d = IDLE;
          if (state_q == IDLE) begin
            close_a = 1'b1;
            res_a.len      = LEN_W'(1);
            res_a.err      = start_err;
            res_a.data_min = snk_data;
            res_a.data_max = snk_data;
          end else begin
            close_b = 1'b1;
            res_b.len      = LEN_W'(1);
            res_b.err      = start_err;
            res_b.data_min = snk_data;
            res_b.data_max = snk_data;
          end
        end
      end
    end

    // A deferred packet always goes out first. While one is pending the FSM is
    // IDLE, so close_b cannot fire and at most one new close needs holding.
    emit       = pend_vld_q | close_a;
    emit_res   = pend_vld_q ? pend_q : res_a;
    pend_vld_d = pend_vld_q ? close_a : close_b;
    pend_d     = pend_vld_q ? res_a : res_b;
  end

  always_ff @(posedge snk_clock) begin
    if (snk_reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      min_q   <= '0;
      err_q   <= '0;
      nosop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      min_q   <= min_d;
      err_q   <= err_d;
      nosop_q <= nosop_d;
    end
  end

  always_ff @(posedge snk_clock) begin
    if (snk_reset) begin
      done_q     <= 1'b0;
      res_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      sticky_q   <= '0;
    end else begin
      done_q     <= emit;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      if (emit) begin
        res_q <= emit_res;
      end
      if (stat_clear) begin
        sticky_q <= '0;
      end else if (emit) begin
        sticky_q <= sticky_q | emit_res.err;
      end
    end
  end

  // Beat count: a starting beat clears and counts to 1; held at MAX_LENGTH+1.
  sort_sat_counter #(.W(LEN_W)) u_beat_cnt (
    .clk   (snk_clock),
    .rst   (snk_reset),
    .clr   (start),
    .inc   (cnt_inc && (start || (cnt_q != LEN_SAT))),
    .count (cnt_q)
  );

  // A clear coinciding with a close must leave the totals at zero.
  sort_sat_counter #(.W(CNT_WIDTH)) u_pkt_cnt (
    .clk   (snk_clock),
    .rst   (snk_reset),
    .clr   (stat_clear),
    .inc   (emit && !stat_clear),
    .count (pkt_count)
  );

  sort_sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
    .clk   (snk_clock),
    .rst   (snk_reset),
    .clr   (stat_clear),
    .inc   (emit && (emit_res.err != '0) && !stat_clear),
    .count (err_count)
  );

  assign pkt_done   = done_q;
  assign pkt_len    = res_q.len;
  assign pkt_err    = res_q.err;
  assign pkt_min    = res_q.data_min;
  assign pkt_max    = res_q.data_max;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_sort_stream_checker.sv
// Bench for sort_stream_checker: directed cases then random beats against a packet-level model.
// Latency: model expects each close one cycle after its beat, queued closes one per cycle.
// Backpressure: none driven; one beat offered per cycle.
module tb_sort_stream_checker;

  localparam int DW   = 16;
  localparam int MAXL = 128;
  localparam int CW   = 4;
  localparam int LW   = $clog2(MAXL) + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          snk_clock;
  logic          snk_reset;
  logic          snk_valid;
  logic          snk_sop;
  logic          snk_eop;
  logic [DW-1:0] snk_data;
  logic          stat_clear;
  logic          pkt_done;
  logic [LW-1:0] pkt_len;
  logic [3:0]    pkt_err;
  logic [DW-1:0] pkt_min;
  logic [DW-1:0] pkt_max;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] err_count;
  logic [3:0]    err_sticky;

  sort_stream_checker #(.DATA_WIDTH(DW), .MAX_LENGTH(MAXL), .CNT_WIDTH(CW)) dut (
    .snk_clock  (snk_clock),
    .snk_reset  (snk_reset),
    .snk_valid  (snk_valid),
    .snk_sop    (snk_sop),
    .snk_eop    (snk_eop),
    .snk_data   (snk_data),
    .stat_clear (stat_clear),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .pkt_err    (pkt_err),
    .pkt_min    (pkt_min),
    .pkt_max    (pkt_max),
    .pkt_count  (pkt_count),
    .err_count  (err_count),
    .err_sticky (err_sticky)
  );

  initial snk_clock = 1'b0;
  always #5 snk_clock = ~snk_clock;

  typedef struct packed {
    logic [LW-1:0] len;
    logic [3:0]    err;
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
  } res_t;

  int total = 0;
  int bad   = 0;

  // Packet-level reference state.
  bit            in_pkt;
  bit            nosop;
  logic [DW-1:0] cur[$];
  logic [3:0]    cur_err;
  res_t          expq[$];
  res_t          held;
  bit            exp_done;
  int            ecnt;
  int            eerr;
  logic [3:0]    esticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic close_pkt(input logic [3:0] e0);
    res_t       r;
    logic [3:0] e;
    int         n;
    e = e0;
    n = cur.size();
    if (n > MAXL) e[2] = 1'b1;
    for (int i = 1; i < n; i++) begin
      if (cur[i] < cur[i-1]) e[0] = 1'b1;
    end
    r.len = (n > MAXL) ? LW'(MAXL + 1) : LW'(n);
    r.err = e;
    r.mn  = cur[0];
    r.mx  = cur[n-1];
    expq.push_back(r);
  endtask

  task automatic model(input bit v, input bit s, input bit e, input logic [DW-1:0] d,
                       input bit clr, input bit rst);
    res_t r;
    if (rst) begin
      in_pkt = 0; nosop = 0; cur.delete(); expq.delete();
      held = '0; exp_done = 0; ecnt = 0; eerr = 0; esticky = '0;
      return;
    end
    if (v) begin
      if (s) begin
        if (in_pkt) close_pkt(cur_err | 4'b0010);
        cur.delete();
        cur.push_back(d);
        cur_err = nosop ? 4'b1000 : 4'b0000;
        nosop   = 0;
        in_pkt  = 1;
        if (e) begin
          close_pkt(cur_err);
          in_pkt = 0;
        end
      end else if (in_pkt) begin
        cur.push_back(d);
        if (e) begin
          close_pkt(cur_err);
          in_pkt = 0;
        end
      end else begin
        nosop = 1;
      end
    end
    exp_done = (expq.size() > 0);
    if (exp_done) begin
      r    = expq.pop_front();
      held = r;
      if (!clr) begin
        ecnt = (ecnt == CMAX) ? CMAX : ecnt + 1;
        if (r.err != 4'b0) eerr = (eerr == CMAX) ? CMAX : eerr + 1;
        esticky = esticky | r.err;
      end
    end
    if (clr) begin
      ecnt = 0; eerr = 0; esticky = '0;
    end
  endtask

  task automatic check_all();
    chk("done",   32'(pkt_done),   32'(exp_done));
    chk("len",    32'(pkt_len),    32'(held.len));
    chk("err",    32'(pkt_err),    32'(held.err));
    chk("min",    32'(pkt_min),    32'(held.mn));
    chk("max",    32'(pkt_max),    32'(held.mx));
    chk("pcount", 32'(pkt_count),  32'(ecnt));
    chk("ecount", 32'(err_count),  32'(eerr));
    chk("sticky", 32'(err_sticky), 32'(esticky));
  endtask

  // One clock: drive at negedge, update the model at the edge, sample 1 time unit later.
  task automatic step(input bit v, input bit s, input bit e, input logic [DW-1:0] d,
                      input bit clr, input bit rst);
    @(negedge snk_clock);
    snk_valid  = v;
    snk_sop    = v ? s : 1'($urandom % 2);
    snk_eop    = v ? e : 1'($urandom % 2);
    snk_data   = v ? d : 'x;
    stat_clear = clr;
    snk_reset  = rst;
    @(posedge snk_clock);
    model(v, s, e, d, clr, rst);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    bit v, s, e, c, r;

    snk_reset = 1'b1; snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    snk_data = '0; stat_clear = 1'b0;
    step(0, 0, 0, '0, 0, 1);
    step(0, 0, 0, '0, 0, 1);
    chk("rst_done",  32'(pkt_done),   32'd0);
    chk("rst_count", 32'(pkt_count),  32'd0);
    chk("rst_stky",  32'(err_sticky), 32'd0);
    idle();

    // 1) clean 5-beat packet, equal values legal
    step(1, 1, 0, 16'd3, 0, 0);
    step(1, 0, 0, 16'd7, 0, 0);
    step(1, 0, 0, 16'd7, 0, 0);
    step(1, 0, 0, 16'd9, 0, 0);
    chk("t1_pre_done", 32'(pkt_done), 32'd0);
    step(1, 0, 1, 16'd200, 0, 0);
    chk("t1_done",  32'(pkt_done),  32'd1);
    chk("t1_len",   32'(pkt_len),   32'd5);
    chk("t1_err",   32'(pkt_err),   32'd0);
    chk("t1_min",   32'(pkt_min),   32'd3);
    chk("t1_max",   32'(pkt_max),   32'd200);
    chk("t1_count", 32'(pkt_count), 32'd1);
    idle();
    chk("t1_pulse", 32'(pkt_done),  32'd0);

    // 2) exactly MAX_LENGTH beats, then MAX_LENGTH+2 beats
    for (int i = 0; i < 128; i++) step(1, i == 0, i == 127, 16'(i), 0, 0);
    chk("t2a_len", 32'(pkt_len), 32'd128);
    chk("t2a_err", 32'(pkt_err), 32'd0);
    for (int i = 0; i < 130; i++) step(1, i == 0, i == 129, 16'(i + 5), 0, 0);
    chk("t2b_len",  32'(pkt_len),   32'd129);
    chk("t2b_err",  32'(pkt_err),   32'b0100);
    chk("t2b_errc", 32'(err_count), 32'd1);
    idle();

    // 3) order violation, then sticky survives a clean packet
    step(1, 1, 0, 16'd10, 0, 0);
    step(1, 0, 0, 16'd20, 0, 0);
    step(1, 0, 0, 16'd5,  0, 0);
    step(1, 0, 1, 16'd30, 0, 0);
    chk("t3_err", 32'(pkt_err), 32'b0001);
    chk("t3_len", 32'(pkt_len), 32'd4);
    step(1, 1, 0, 16'd1, 0, 0);
    step(1, 0, 1, 16'd2, 0, 0);
    chk("t3_clean_err", 32'(pkt_err),       32'd0);
    chk("t3_sticky0",   32'(err_sticky[0]), 32'd1);

    // 4) sop inside packet with eop: two consecutive closes
    step(1, 1, 0, 16'd1, 0, 0);
    step(1, 0, 0, 16'd2, 0, 0);
    step(1, 1, 1, 16'd3, 0, 0);
    chk("t4a_done", 32'(pkt_done), 32'd1);
    chk("t4a_len",  32'(pkt_len),  32'd2);
    chk("t4a_err",  32'(pkt_err),  32'b0010);
    idle();
    chk("t4b_done", 32'(pkt_done), 32'd1);
    chk("t4b_len",  32'(pkt_len),  32'd1);
    chk("t4b_err",  32'(pkt_err),  32'd0);
    chk("t4b_min",  32'(pkt_min),  32'd3);
    chk("t4b_max",  32'(pkt_max),  32'd3);
    idle();

    // 5) orphan beat marks the next packet
    step(1, 0, 0, 16'h55, 0, 0);
    idle();
    step(1, 1, 0, 16'd4, 0, 0);
    step(1, 0, 1, 16'd6, 0, 0);
    chk("t5_err", 32'(pkt_err), 32'b1000);
    chk("t5_len", 32'(pkt_len), 32'd2);
    idle();

    // 6) reset mid-packet, then clean packet, then stat_clear
    step(1, 1, 0, 16'd1, 0, 0);
    step(1, 0, 0, 16'd2, 0, 0);
    step(1, 0, 1, 16'd3, 0, 1);
    idle();
    chk("t6_no_done", 32'(pkt_done), 32'd0);
    step(1, 1, 0, 16'd5, 0, 0);
    step(1, 0, 0, 16'd6, 0, 0);
    step(1, 0, 1, 16'd7, 0, 0);
    chk("t6_count", 32'(pkt_count), 32'd1);
    chk("t6_len",   32'(pkt_len),   32'd3);
    step(0, 0, 0, '0, 1, 0);
    chk("t6_clr_count", 32'(pkt_count),  32'd0);
    chk("t6_clr_errc",  32'(err_count),  32'd0);
    chk("t6_clr_stky",  32'(err_sticky), 32'd0);

    // Random beats with occasional clears and resets; counters are narrow so they saturate.
    rd = '0;
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom % 4) != 0;
      s = ($urandom % 6) == 0;
      e = ($urandom % 5) == 0;
      c = ($urandom % 90) == 0;
      r = ($urandom % 500) == 0;
      if (($urandom % 8) == 0) rd = 16'($urandom);
      else rd = rd + 16'($urandom % 4);
      step(v, s, e, rd, c, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
